gem_cluster_sequencer: RTL and testbench
========================================

// Module: gem_cluster_sequencer
// PURPOSE
//  Upstream feeder for the GEM-cluster-to-CSC wire/halfstrip converter.
//  Each BX it captures NCLUST raw 14-bit GEM clusters and serialises the valid ones, lowest index first.
//  It emits one per clock, decoded into roll/pad/size, for the single-cluster LUT stage downstream.
//  Clusters not drained before the next BX load are dropped and counted.
// PARAMETERS
//  NCLUST    8      clusters captured per BX (2..8)
//  NPADS     192    pads per roll; an address is valid if < 8*NPADS (1536)
//  DROPBITS  8      width of saturating dropped-cluster counter
// PORTS
//  clock            in   1         fabric clock; all logic on rising edge
//  reset_n          in   1         asynchronous, active-low reset
//  clusters_in      in   NCLUST*14 cluster i = [14*i+13:14*i]; [10:0]=address 0-1535, [13:11]=size
//  clusters_load    in   1         one-cycle strobe: capture clusters_in
//  cluster0         out  14        raw cluster word being presented
//  cluster0_vpf     out  1         cluster0_* fields valid this cycle
//  cluster0_roll    out  3         address / NPADS (0-7)
//  cluster0_pad     out  8         address % NPADS (0-191)
//  cluster0_size    out  3         cluster[13:11]; 0 = one pad
//  cluster0_index   out  3         source slot of presented cluster
//  cluster0_last    out  1         presented cluster is the last one of this load
//  busy             out  1         SCAN state; undrained clusters remain
//  nclusters        out  4         number of valid clusters in the latest load
//  dropped_cnt      out  DROPBITS  saturating count of clusters discarded by reload
// BEHAVIOUR
//  Reset: all outputs 0, mask 0, state IDLE. Reset mid-scan abandons the load with no drop count.
//  Validity: slot valid iff address[10:0] < 8*NPADS. Size is not checked.
//    Invalid slots are never emitted and never counted.
//  Capture at edge k (clusters_load=1):
//    - Store words; mask = per-slot validity; nclusters = popcount(mask), registered at edge k.
//    - mask==0: go to IDLE, emit nothing.
//    - mask!=0: go to SCAN.
//  SCAN: at each edge from k+1, sel = lowest set bit of mask.
//    - Register cluster0/roll/pad/size/index from slot sel; cluster0_vpf=1.
//    - Clear mask[sel].
//    - cluster0_last=1 when the remaining mask is empty; then return to IDLE.
//    - First output at edge k+1. n valid clusters occupy edges k+1..k+n back-to-back.
//  IDLE, or a cycle with nothing emitted:
//    - cluster0_vpf=0 and cluster0_last=0.
//    - cluster0/roll/pad/size/index hold their last values.
//  busy = (state==SCAN). It is registered with the state.
//  Decode:
//    - roll = count of thresholds {192,384,...,1344} that are <= address.
//    - pad = address - roll*NPADS (8-bit).
//    - Pure comparators/subtract, no divider; fits in the single output register stage.
//  Reload during SCAN (clusters_load=1 while mask has m bits set before this edge's emission):
//    - The emission scheduled for this edge still occurs, taken from the old mask.
//    - The remaining m-1 clusters are discarded.
//    - dropped_cnt += m-1, saturating at all-ones.
//    - The new load is captured as in IDLE; the next edge emits from the new mask.
//    - Load coincident with the last emission (m=1): no drop.
//    - cluster0_last=1 on that last emission in all cases, including when a reload discards clusters.
//  Load with mask 0 during SCAN: the old remainder is still dropped and counted; state goes to IDLE.
//  Downstream has no backpressure; one cluster per clock is always accepted.
// TESTING
//  1. Reset, then load slots 2,5 = 0x0C5 (addr 197, size 0), 0x2600 (addr 1536, invalid) ->
//     edge k+1: vpf=1, index=2, roll=1, pad=5, last=1; nclusters=1; no second output.
//  2. Load 8 valid clusters addr 0,191,192,383,1343,1344,1535,700 ->
//     8 consecutive vpf cycles, index 0..7.
//     roll/pad = 0/0, 0/191, 1/0, 1/191, 6/191, 7/0, 7/191, 3/124. last only on 8th.
//  3. Load 6 valid clusters, reload 6 valid clusters two edges later ->
//     2 old emissions plus the emission at the reload edge, then 6 new emissions.
//     dropped_cnt=3.
//  4. Load with all addresses 0x7FF -> nclusters=0, busy=0, vpf stays 0, dropped_cnt unchanged.
//  5. Assert reset_n=0 asynchronously mid-scan ->
//     all outputs 0 immediately. After release: IDLE, no residual emission.
//  6. Force 300 drops via repeated reloads -> dropped_cnt saturates at 255, no wrap.

Source files
------------

// File: rtl/gem_cluster_sequencer.sv
// GEM cluster sequencer: captures NCLUST raw clusters per BX and presents the
// valid ones one per clock, lowest slot first, decoded into roll/pad/size.
// Clusters still pending when a new load arrives are dropped and counted.
module gem_cluster_sequencer #(
  parameter int NCLUST   = 8,
  parameter int NPADS    = 192,
  parameter int DROPBITS = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NCLUST*14-1:0]  clusters_in,
  input  logic                  clusters_load,
  output logic [13:0]           cluster0,
  output logic                  cluster0_vpf,
  output logic [2:0]            cluster0_roll,
  output logic [7:0]            cluster0_pad,
  output logic [2:0]            cluster0_size,
  output logic [2:0]            cluster0_index,
  output logic                  cluster0_last,
  output logic                  busy,
  output logic [3:0]            nclusters,
  output logic [DROPBITS-1:0]   dropped_cnt
);

  localparam int unsigned ADDR_LIMIT = 8 * NPADS;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_q, state_d;
  logic [NCLUST-1:0]   mask_q, mask_d;
  logic [13:0]         words_q [NCLUST];
  logic [13:0]         words_d [NCLUST];
  logic [13:0]         cluster0_q, cluster0_d;
  logic                vpf_q, vpf_d;
  logic [2:0]          roll_q, roll_d;
  logic [7:0]          pad_q, pad_d;
  logic [2:0]          size_q, size_d;
  logic [2:0]          index_q, index_d;
  logic                last_q, last_d;
  logic [3:0]          nclusters_q, nclusters_d;
  logic [DROPBITS-1:0] dropped_q, dropped_d;

  // Combinational helpers
  logic [NCLUST-1:0]   new_mask;
  logic [NCLUST-1:0]   rem_mask;
  logic [2:0]          sel;
  logic                sel_found;
  logic                emit;
  logic [13:0]         sel_word;
  logic [11:0]         sel_addr;
  logic [11:0]         roll_base;
  logic [2:0]          roll_v;
  logic [11:0]         pad_full;
  logic [3:0]          new_count;
  logic [3:0]          rem_count;
  logic [DROPBITS+3:0] drop_sum;

  // Slot validity of the incoming bus and its population count
  always_comb begin
    new_mask  = '0;
    new_count = '0;
    for (int unsigned i = 0; i < NCLUST; i++) begin
      new_mask[i] = ({1'b0, clusters_in[14*i +: 11]} < 12'(ADDR_LIMIT));
      new_count   = new_count + {3'b000, new_mask[i]};
    end
  end

  // Lowest pending slot, the mask left after taking it, and its roll/pad decode
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NCLUST; i++) begin
      if (!sel_found && mask_q[i]) begin
        sel       = 3'(i);
        sel_found = 1'b1;
      end
    end
    // Clearing the lowest set bit is exactly the selected slot
    rem_mask  = mask_q & (mask_q - 1'b1);
    rem_count = '0;
    for (int unsigned i = 0; i < NCLUST; i++) begin
      rem_count = rem_count + {3'b000, rem_mask[i]};
    end
    emit      = (state_q == SCAN) && (mask_q != '0);
    sel_word  = words_q[sel];
    sel_addr  = {1'b0, sel_word[10:0]};
    roll_v    = '0;
    roll_base = '0;
    // Roll by threshold compare; pad by subtracting the matched threshold
    for (int unsigned t = 1; t < 8; t++) begin
      if (sel_addr >= 12'(t * NPADS)) begin
        roll_v    = 3'(t);
        roll_base = 12'(t * NPADS);
      end
    end
    pad_full = sel_addr - roll_base;
  end

  // Next-state, capture, emission and drop accounting
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    words_d     = words_q;
    cluster0_d  = cluster0_q;
    vpf_d       = 1'b0;
    roll_d      = roll_q;
    pad_d       = pad_q;
    size_d      = size_q;
    index_d     = index_q;
    last_d      = 1'b0;
    nclusters_d = nclusters_q;
    dropped_d   = dropped_q;
    drop_sum    = '0;

    if (emit) begin
      cluster0_d = sel_word;
      vpf_d      = 1'b1;
      roll_d     = roll_v;
      pad_d      = pad_full[7:0];
      size_d     = sel_word[13:11];
      index_d    = sel;
      // A reload ends the current load, so this emission is its last
      last_d     = (rem_mask == '0) || clusters_load;
      mask_d     = rem_mask;
      state_d    = (rem_mask != '0) ? SCAN : IDLE;
    end

    if (clusters_load) begin
      for (int unsigned i = 0; i < NCLUST; i++) begin
        words_d[i] = clusters_in[14*i +: 14];
      end
      mask_d      = new_mask;
      nclusters_d = new_count;
      state_d     = (new_mask != '0) ? SCAN : IDLE;
      if (emit) begin
        drop_sum  = {4'b0000, dropped_q} + {{DROPBITS{1'b0}}, rem_count};
        dropped_d = (drop_sum[DROPBITS+3:DROPBITS] != '0) ? '1 : drop_sum[DROPBITS-1:0];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      for (int unsigned i = 0; i < NCLUST; i++) words_q[i] <= '0;
      cluster0_q  <= '0;
      vpf_q       <= 1'b0;
      roll_q      <= '0;
      pad_q       <= '0;
      size_q      <= '0;
      index_q     <= '0;
      last_q      <= 1'b0;
      nclusters_q <= '0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      words_q     <= words_d;
      cluster0_q  <= cluster0_d;
      vpf_q       <= vpf_d;
      roll_q      <= roll_d;
      pad_q       <= pad_d;
      size_q      <= size_d;
      index_q     <= index_d;
      last_q      <= last_d;
      nclusters_q <= nclusters_d;
      dropped_q   <= dropped_d;
    end
  end

  assign cluster0       = cluster0_q;
  assign cluster0_vpf   = vpf_q;
  assign cluster0_roll  = roll_q;
  assign cluster0_pad   = pad_q;
  assign cluster0_size  = size_q;
  assign cluster0_index = index_q;
  assign cluster0_last  = last_q;
  assign busy           = (state_q == SCAN);
  assign nclusters      = nclusters_q;
  assign dropped_cnt    = dropped_q;

endmodule

// File: tb/tb_gem_cluster_sequencer.sv
// Scoreboard bench for gem_cluster_sequencer: stimulus pushes hand-computed
// emissions into a queue; a monitor pops and compares on every vpf cycle.
module tb_gem_cluster_sequencer;

  logic         clock;
  logic         reset_n;
  logic [111:0] clusters_in;
  logic         clusters_load;
  logic [13:0]  cluster0;
  logic         cluster0_vpf;
  logic [2:0]   cluster0_roll;
  logic [7:0]   cluster0_pad;
  logic [2:0]   cluster0_size;
  logic [2:0]   cluster0_index;
  logic         cluster0_last;
  logic         busy;
  logic [3:0]   nclusters;
  logic [7:0]   dropped_cnt;

  gem_cluster_sequencer #(.NCLUST(8), .NPADS(192), .DROPBITS(8)) dut (
    .clock(clock), .reset_n(reset_n), .clusters_in(clusters_in),
    .clusters_load(clusters_load), .cluster0(cluster0), .cluster0_vpf(cluster0_vpf),
    .cluster0_roll(cluster0_roll), .cluster0_pad(cluster0_pad),
    .cluster0_size(cluster0_size), .cluster0_index(cluster0_index),
    .cluster0_last(cluster0_last), .busy(busy), .nclusters(nclusters),
    .dropped_cnt(dropped_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [13:0] w;
    logic [2:0]  roll;
    logic [7:0]  pad;
    logic [2:0]  size;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [13:0] slot [8];

  // Test 2 set: addresses with hand-decoded roll/pad, size = slot number
  int t2_addr [8] = '{0, 191, 192, 383, 1343, 1344, 1535, 700};
  int t2_roll [8] = '{0, 0, 1, 1, 6, 7, 7, 3};
  int t2_pad  [8] = '{0, 191, 0, 191, 191, 0, 191, 124};

  function automatic logic [13:0] mk(input int sz, input int addr);
    return 14'((sz << 11) | addr);
  endfunction

  task automatic push_exp(input logic [13:0] w, input int roll, input int pad,
                          input int size, input int idx, input bit last);
    exp_t e;
    e.w = w; e.roll = 3'(roll); e.pad = 8'(pad); e.size = 3'(size);
    e.idx = 3'(idx); e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic pulse_load();
    @(negedge clock);
    for (int i = 0; i < 8; i++) clusters_in[14*i +: 14] = slot[i];
    clusters_load = 1'b1;
    @(negedge clock);
    clusters_load = 1'b0;
  endtask

  task automatic set_t2();
    for (int i = 0; i < 8; i++) slot[i] = mk(i, t2_addr[i]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 80) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (busy || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: busy=%0d pending=%0d, required busy=0 pending=0",
               name, busy, exp_q.size());
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_cluster0"}, 32'(cluster0), 0);
    chk({name, "_vpf"}, 32'(cluster0_vpf), 0);
    chk({name, "_roll"}, 32'(cluster0_roll), 0);
    chk({name, "_pad"}, 32'(cluster0_pad), 0);
    chk({name, "_size"}, 32'(cluster0_size), 0);
    chk({name, "_index"}, 32'(cluster0_index), 0);
    chk({name, "_last"}, 32'(cluster0_last), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_nclusters"}, 32'(nclusters), 0);
    chk({name, "_dropped"}, 32'(dropped_cnt), 0);
  endtask

  // Monitor: every emission must match the head of the expected queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (cluster0_vpf) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_emission: got index=%0d cluster=%h, required no output",
                     cluster0_index, cluster0);
          end else begin
            e = exp_q.pop_front();
            if ({cluster0, cluster0_roll, cluster0_pad, cluster0_size, cluster0_index,
                 cluster0_last} !== e) begin
              miscompares++;
              $display("FAIL emission: got w=%h roll=%0d pad=%0d size=%0d idx=%0d last=%0d, required w=%h roll=%0d pad=%0d size=%0d idx=%0d last=%0d",
                       cluster0, cluster0_roll, cluster0_pad, cluster0_size, cluster0_index,
                       cluster0_last, e.w, e.roll, e.pad, e.size, e.idx, e.last);
            end
          end
        end else if (cluster0_last !== 1'b0) begin
          vectors++;
          miscompares++;
          $display("FAIL last_without_vpf: got last=%0d, required 0", cluster0_last);
        end
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    clusters_in   = '0;
    clusters_load = 1'b0;
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // 1: slot2 valid (addr 197), slot5 addr 1536 invalid, rest invalid
    for (int i = 0; i < 8; i++) slot[i] = 14'h07FF;
    slot[2] = 14'h00C5;
    slot[5] = 14'h2600;
    push_exp(14'h00C5, 1, 5, 0, 2, 1'b1);
    pulse_load();
    chk("t1_nclusters", 32'(nclusters), 1);
    chk("t1_busy", 32'(busy), 1);
    wait_drain("t1");
    repeat (3) @(negedge clock);

    // 2: eight valid clusters across roll boundaries
    set_t2();
    for (int i = 0; i < 8; i++) push_exp(slot[i], t2_roll[i], t2_pad[i], i, i, i == 7);
    pulse_load();
    chk("t2_nclusters", 32'(nclusters), 8);
    wait_drain("t2");
    chk("t2_dropped", 32'(dropped_cnt), 0);

    // 3: six valid, reload at the third emission edge -> 3 dropped
    slot = '{mk(1, 10), mk(2, 200), mk(3, 400), mk(4, 600), mk(5, 800), mk(6, 1000),
             14'h07FF, 14'h07FF};
    push_exp(mk(1, 10), 0, 10, 1, 0, 1'b0);
    push_exp(mk(2, 200), 1, 8, 2, 1, 1'b0);
    push_exp(mk(3, 400), 2, 16, 3, 2, 1'b1);
    push_exp(mk(0, 5), 0, 5, 0, 1, 1'b0);
    push_exp(mk(1, 250), 1, 58, 1, 2, 1'b0);
    push_exp(mk(2, 450), 2, 66, 2, 3, 1'b0);
    push_exp(mk(3, 650), 3, 74, 3, 4, 1'b0);
    push_exp(mk(4, 850), 4, 82, 4, 5, 1'b0);
    push_exp(mk(5, 1100), 5, 140, 5, 6, 1'b1);
    pulse_load();
    @(negedge clock);
    slot = '{14'h07FF, mk(0, 5), mk(1, 250), mk(2, 450), mk(3, 650), mk(4, 850),
             mk(5, 1100), 14'h07FF};
    pulse_load();
    chk("t3_dropped_at_reload", 32'(dropped_cnt), 3);
    chk("t3_nclusters", 32'(nclusters), 6);
    wait_drain("t3");
    chk("t3_dropped", 32'(dropped_cnt), 3);

    // 4: all invalid while idle
    for (int i = 0; i < 8; i++) slot[i] = 14'h07FF;
    pulse_load();
    chk("t4_nclusters", 32'(nclusters), 0);
    chk("t4_busy", 32'(busy), 0);
    repeat (3) @(negedge clock);
    chk("t4_dropped", 32'(dropped_cnt), 3);

    // 4b: all-invalid reload during scan still drops the remainder (7-1 = 6)
    set_t2();
    push_exp(slot[0], 0, 0, 0, 0, 1'b0);
    push_exp(slot[1], 0, 191, 1, 1, 1'b1);
    pulse_load();
    for (int i = 0; i < 8; i++) slot[i] = 14'h07FF;
    pulse_load();
    chk("t4b_busy", 32'(busy), 0);
    chk("t4b_nclusters", 32'(nclusters), 0);
    chk("t4b_dropped", 32'(dropped_cnt), 9);
    wait_drain("t4b");
    repeat (2) @(negedge clock);

    // 5: asynchronous reset mid-scan
    set_t2();
    push_exp(slot[0], 0, 0, 0, 0, 1'b0);
    push_exp(slot[1], 0, 191, 1, 1, 1'b0);
    pulse_load();
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("t5_async");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_pending", 32'(exp_q.size()), 0);

    // 6: load held high: capture then 43 reloads x 7 drops = 301 -> saturate
    set_t2();
    for (int i = 0; i < 43; i++) push_exp(slot[0], 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) push_exp(slot[i], t2_roll[i], t2_pad[i], i, i, i == 7);
    @(negedge clock);
    for (int i = 0; i < 8; i++) clusters_in[14*i +: 14] = slot[i];
    clusters_load = 1'b1;
    repeat (11) @(negedge clock);
    chk("t6_dropped_partial", 32'(dropped_cnt), 70);
    repeat (33) @(negedge clock);
    clusters_load = 1'b0;
    wait_drain("t6");
    chk("t6_dropped_sat", 32'(dropped_cnt), 255);
    chk("t6_nclusters", 32'(nclusters), 8);
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
